// File: rtl/gpio_uart_tx_if.sv
// GPIO store path between the memory controller and the UART transmit responder.
// The master drives the store byte and strobe; the slave returns FIFO/line status.
interface gpio_uart_tx_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    gpio_data;
  logic          gpio_en;
  logic          busy;
  logic          full;
  logic          empty;
  logic          overflow;
  logic [CW-1:0] count;

  modport master (
    output gpio_data, gpio_en,
    input  busy, full, empty, overflow, count
  );

  modport slave (
    input  gpio_data, gpio_en,
    output busy, full, empty, overflow, count
  );
endinterface

// File: rtl/gpio_uart_tx.sv
// Buffers GPIO store bytes in a small FIFO and serialises each one as an 8N1 UART frame.
// Status flags let software poll for room before storing.
module gpio_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH        = 4
) (
  input  logic         clk,
  input  logic         rst,
  gpio_uart_tx_if.slave bus,
  output logic         tx
);
  // state | meaning
  // IDLE  | line high, waiting for a buffered byte
  // START | start bit (low) for one bit period
  // DATA  | eight data bits, LSB first
  // STOP  | stop bit (high) for one bit period

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          ovf;
  logic          pop;
  logic          push;
  logic          bit_end;

  // A pop on the same edge frees a slot, so a store into a full FIFO is still accepted.
  always_comb begin
    pop     = (state == IDLE) && (cnt != '0);
    push    = bus.gpio_en && ((cnt != DEPTH_C) || pop);
    bit_end = (baud_cnt == BAUD_LAST);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.gpio_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (bus.gpio_en && !push) begin
        ovf <= 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // tx is loaded with the level of the bit about to start, so the line is purely registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift    <= mem[rd_ptr];
            baud_cnt <= '0;
            tx       <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            shift    <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.full     = (cnt == DEPTH_C);
  assign bus.empty    = (cnt == '0);
  assign bus.overflow = ovf;
  assign bus.count    = cnt;
endmodule

// File: tb/tb_gpio_uart_tx.sv
// Randomised bench for gpio_uart_tx against a queue-and-frame-timer reference model.
module tb_gpio_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx;
  logic [7:0] dut_status;

  gpio_uart_tx_if #(.DEPTH(DEPTH)) bus ();

  gpio_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave),
    .tx  (tx)
  );

  always #5 clk = ~clk;

  assign dut_status = {tx, bus.busy, bus.full, bus.empty, bus.overflow, bus.count};

  int total = 0;
  int bad   = 0;

  // Reference: a byte queue plus the number of cycles left in the frame on the wire.
  logic [7:0] mq[$];
  int         frame_left;
  logic [7:0] cur;
  logic       m_ovf;
  logic [0:9] lv_a5 = 10'b0101001011;

  function automatic void model_reset();
    mq.delete();
    frame_left = 0;
    cur        = 8'h00;
    m_ovf      = 1'b0;
  endfunction

  function automatic void model_step(input logic en, input logic [7:0] d);
    logic pop;
    int   sz;
    pop = (frame_left == 0) && (mq.size() > 0);
    sz  = mq.size();
    if (frame_left > 0) frame_left--;
    if (pop) begin
      cur        = mq.pop_front();
      frame_left = FRAME;
    end
    if (en) begin
      if (sz < DEPTH || pop) mq.push_back(d);
      else m_ovf = 1'b1;
    end
  endfunction

  function automatic logic model_tx();
    int e;
    int b;
    if (frame_left == 0) return 1'b1;
    e = FRAME - frame_left;
    b = e / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return cur[b-1];
    return 1'b1;
  endfunction

  function automatic logic [7:0] model_status();
    return {model_tx(), frame_left > 0, mq.size() == DEPTH, mq.size() == 0, m_ovf, 3'(mq.size())};
  endfunction

  // One clock of stimulus; returns at the following falling edge with outputs settled.
  task automatic tick(input logic en, input logic [7:0] d);
    bus.gpio_en   = en;
    bus.gpio_data = d;
    @(posedge clk);
    if (rst) model_step(en, d);
    else model_reset();
    @(negedge clk);
    bus.gpio_en   = 1'b0;
    bus.gpio_data = 8'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) tick(1'b0, 8'h00);
    rst = 1'b1;
    tick(1'b0, 8'h00);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    repeat (3) tick(1'b0, 8'h00);
    total++;
    if (dut_status !== 8'b1001_0000) begin
      bad++;
      $display("FAIL reset_state: got %b expected %b", dut_status, 8'b1001_0000);
    end
    rst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick(1'b0, 8'($urandom));
      total++;
      if (tx !== 1'b1 || dut_status !== model_status()) begin
        bad++;
        $display("FAIL reset_idle: cycle %0d got %b expected %b", i, dut_status, model_status());
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    tick(1'b1, 8'hA5);
    total++;
    if ({tx, bus.busy, bus.empty, bus.count} !== {1'b1, 1'b0, 1'b0, 3'd1}) begin
      bad++;
      $display("FAIL single_push: got tx/busy/empty/count %b expected 1_0_0_001",
               {tx, bus.busy, bus.empty, bus.count});
    end
    tick(1'b0, 8'($urandom));
    total++;
    if ({tx, bus.busy, bus.empty} !== 3'b011) begin
      bad++;
      $display("FAIL single_pop: got tx/busy/empty %b expected 011", {tx, bus.busy, bus.empty});
    end
    for (int i = 0; i < FRAME; i++) begin
      total++;
      if (tx !== lv_a5[i/CPB] || dut_status !== model_status()) begin
        bad++;
        $display("FAIL single_frame: cycle %0d got tx=%b status %b expected tx=%b status %b",
                 i, tx, dut_status, lv_a5[i/CPB], model_status());
      end
      tick(1'b0, 8'($urandom));
    end
    total++;
    if (bus.busy !== 1'b0 || tx !== 1'b1) begin
      bad++;
      $display("FAIL single_end: got busy=%b tx=%b expected busy=0 tx=1", bus.busy, tx);
    end
  endtask

  task automatic test_burst(input int n_push, input string tag);
    int   peak;
    logic saw_full;
    int   starts[$];
    logic prev_busy;
    int   cyc;
    do_reset();
    peak = 0; saw_full = 1'b0; prev_busy = 1'b0; cyc = 0;
    for (int c = 0; c < n_push + 240; c++) begin
      if (c < n_push) tick(1'b1, 8'(c + 1));
      else tick(1'b0, 8'($urandom));
      cyc++;
      if (int'(bus.count) > peak) peak = int'(bus.count);
      saw_full |= bus.full;
      if (!prev_busy && bus.busy) starts.push_back(cyc);
      prev_busy = bus.busy;
      total++;
      if (dut_status !== model_status()) begin
        bad++;
        $display("FAIL %s_model: cycle %0d got %b expected %b", tag, c, dut_status, model_status());
      end
    end
    total++;
    if (peak != DEPTH || !saw_full) begin
      bad++;
      $display("FAIL %s_peak: got peak=%0d full_seen=%b expected %0d 1", tag, peak, saw_full, DEPTH);
    end
    total++;
    if (bus.overflow !== (n_push > DEPTH + 1)) begin
      bad++;
      $display("FAIL %s_overflow: got %b expected %b", tag, bus.overflow, n_push > DEPTH + 1);
    end
    total++;
    if (starts.size() != 5) begin
      bad++;
      $display("FAIL %s_frames: got %0d expected 5", tag, starts.size());
    end else begin
      for (int k = 1; k < 5; k++) begin
        total++;
        if (starts[k] - starts[k-1] != FRAME + 1) begin
          bad++;
          $display("FAIL %s_spacing: got %0d expected %0d", tag, starts[k] - starts[k-1], FRAME + 1);
        end
      end
    end
  endtask

  task automatic test_full_pop();
    logic       hist[$];
    int         starts[$];
    logic       prev_busy;
    logic [7:0] got;
    int         s;
    int         guard;
    do_reset();
    tick(1'b1, 8'h3C);
    tick(1'b0, 8'($urandom));
    tick(1'b1, 8'h11);
    tick(1'b1, 8'h22);
    tick(1'b1, 8'h33);
    tick(1'b1, 8'h44);
    total++;
    if (bus.count !== 3'd4 || bus.full !== 1'b1) begin
      bad++;
      $display("FAIL fullpop_fill: got count=%0d full=%b expected 4 1", bus.count, bus.full);
    end
    guard = 0;
    while (!(frame_left == 0 && mq.size() > 0) && guard < 100) begin
      tick(1'b0, 8'($urandom));
      guard++;
      total++;
      if (dut_status !== model_status()) begin
        bad++;
        $display("FAIL fullpop_wait: got %b expected %b", dut_status, model_status());
      end
    end
    total++;
    if (guard >= 100) begin
      bad++;
      $display("FAIL fullpop_timeout: got %0d cycles expected under 100", guard);
    end
    tick(1'b1, 8'h77);
    total++;
    if ({bus.count, bus.overflow, bus.busy} !== {3'd4, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL fullpop_edge: got count=%0d ovf=%b busy=%b expected 4 0 1",
               bus.count, bus.overflow, bus.busy);
    end
    prev_busy = 1'b1;
    for (int c = 0; c < 5 * (FRAME + 1) + 10; c++) begin
      tick(1'b0, 8'($urandom));
      hist.push_back(tx);
      if (!prev_busy && bus.busy) starts.push_back(hist.size() - 1);
      prev_busy = bus.busy;
      total++;
      if (dut_status !== model_status()) begin
        bad++;
        $display("FAIL fullpop_model: cycle %0d got %b expected %b", c, dut_status, model_status());
      end
    end
    total++;
    if (starts.size() != 4) begin
      bad++;
      $display("FAIL fullpop_frames: got %0d expected 4", starts.size());
    end else begin
      s = starts[3];
      for (int b = 0; b < 8; b++) got[b] = hist[s + CPB * (b + 1) + CPB / 2];
      total++;
      if (got !== 8'h77) begin
        bad++;
        $display("FAIL fullpop_last_byte: got %h expected 77", got);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(1'b1, 8'hFF);
    tick(1'b0, 8'($urandom));
    tick(1'b1, 8'h5A);
    repeat (16) tick(1'b0, 8'($urandom));
    total++;
    if (dut_status !== model_status()) begin
      bad++;
      $display("FAIL midreset_pre: got %b expected %b", dut_status, model_status());
    end
    rst = 1'b0;
    #1;
    total++;
    if ({tx, bus.busy, bus.count, bus.empty} !== {1'b1, 1'b0, 3'd0, 1'b1}) begin
      bad++;
      $display("FAIL midreset_async: got tx/busy/count/empty %b expected 1_0_000_1",
               {tx, bus.busy, bus.count, bus.empty});
    end
    model_reset();
    repeat (2) tick(1'b0, 8'($urandom));
    rst = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick(1'b0, 8'($urandom));
      total++;
      if (tx !== 1'b1 || dut_status !== model_status()) begin
        bad++;
        $display("FAIL midreset_quiet: cycle %0d got %b expected %b", i, dut_status, model_status());
      end
    end
    tick(1'b1, 8'h00);
    tick(1'b0, 8'($urandom));
    total++;
    if (tx !== 1'b0) begin
      bad++;
      $display("FAIL midreset_restart: got tx=%b expected 0", tx);
    end
    rst = 1'b0;
    #1;
    total++;
    if (tx !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_start_bit: got tx=%b busy=%b expected 1 0", tx, bus.busy);
    end
    model_reset();
    tick(1'b0, 8'h00);
    rst = 1'b1;
    tick(1'b0, 8'h00);
  endtask

  task automatic test_random();
    logic en;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      en = ($urandom_range(0, 99) < ((c < 400) ? 3 : 40));
      tick(en, 8'($urandom));
      total++;
      if (dut_status !== model_status()) begin
        bad++;
        $display("FAIL random_model: cycle %0d got %b expected %b", c, dut_status, model_status());
      end
    end
  endtask

  initial begin
    bus.gpio_en   = 1'b0;
    bus.gpio_data = 8'h00;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single();
    test_burst(5, "burst");
    test_burst(6, "overflow");
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
